// File: rtl/lsq_pkg.sv
// lsq_pkg: opcodes, issue FSM encoding and access-width helpers shared by
// the load/store queue and its load extension unit.
package lsq_pkg;

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } lsq_state_e;

  // Bytes moved by a memory op; anything that is not byte/half is a word.
  function automatic logic [2:0] opWidth(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Mask that keeps only the bytes a store of the given width writes.
  function automatic logic [31:0] widthMask(input logic [2:0] w);
    case (w)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: turns the raw word returned by memory into the architectural
// load result (sign- or zero-extension of byte/half loads).
module load_extend
  import lsq_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  // Select the extension for the load flavour; words pass through untouched.
  always_comb begin
    ext_o = raw_i;
    case (op_i)
      OP_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OP_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OP_LBU:  ext_o = {24'h0, raw_i[7:0]};
      OP_LHU:  ext_o = {16'h0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// load_store_queue: in-order circular load/store queue that waits for its
// operands on the CDB, issues one memory access at a time and reports
// completions to the ROB. Optional macro LSQ_ALU_SNOOP_EN adds the ALU CDB
// snoop port so ALU results can also wake waiting entries.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int LSQ_DEPTH = 16,
  parameter int ROB_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  output logic             lsq_full,
  input  logic             task_in,
  input  logic [5:0]       op_type,
  input  logic [31:0]      vj_in,
  input  logic [31:0]      vk_in,
  input  logic [31:0]      imm_in,
  input  logic [ROB_W-1:0] qj_in,
  input  logic [ROB_W-1:0] qk_in,
  input  logic             j_in,
  input  logic             k_in,
  input  logic [ROB_W-1:0] dest_in,
  output logic             go_work,
  output logic             l_or_s,
  output logic [2:0]       width,
  output logic [31:0]      address,
  output logic [31:0]      value_store,
  input  logic             received,
  input  logic             has_result,
  input  logic [31:0]      value_load,
  input  logic [ROB_W-1:0] rob_head,
`ifdef LSQ_ALU_SNOOP_EN
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_id,
  input  logic [31:0]      alu_value,
`endif
  output logic             lb_to_rob,
  output logic [ROB_W-1:0] load_id,
  output logic [31:0]      value,
  output logic             sb_to_rob,
  output logic [ROB_W-1:0] store_id
);

  localparam int PTR_W = $clog2(LSQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_state_e state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LSQ_DEPTH-1:0] busy_q, busy_d, j_q, j_d, k_q, k_d;
  logic [5:0]       op_q  [LSQ_DEPTH], op_d  [LSQ_DEPTH];
  logic [31:0]      vj_q  [LSQ_DEPTH], vj_d  [LSQ_DEPTH];
  logic [31:0]      vk_q  [LSQ_DEPTH], vk_d  [LSQ_DEPTH];
  logic [31:0]      imm_q [LSQ_DEPTH], imm_d [LSQ_DEPTH];
  logic [ROB_W-1:0] qj_q  [LSQ_DEPTH], qj_d  [LSQ_DEPTH];
  logic [ROB_W-1:0] qk_q  [LSQ_DEPTH], qk_d  [LSQ_DEPTH];
  logic [ROB_W-1:0] tag_q [LSQ_DEPTH], tag_d [LSQ_DEPTH];

  logic goWork_q, goWork_d, lOrS_q, lOrS_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] address_q, address_d, valueStore_q, valueStore_d;
  logic [ROB_W-1:0] issuedTag_q, issuedTag_d;
  logic [5:0]  issuedOp_q, issuedOp_d;
  logic flushed_q, flushed_d;
  logic lbToRob_q, lbToRob_d, sbToRob_q, sbToRob_d;
  logic [ROB_W-1:0] loadId_q, loadId_d, storeId_q, storeId_d;
  logic [31:0] value_q, value_d;

  logic push, pop, loadBcast, discard;
  logic [31:0] extValue;
  logic [5:0]  headOp;
  logic [2:0]  headWidth;

  load_extend u_load_extend (
    .op_i  (issuedOp_q),
    .raw_i (value_load),
    .ext_o (extValue)
  );

  assign headOp    = op_q[head_q];
  assign headWidth = opWidth(headOp);
  assign lsq_full  = (count_q == CNT_W'(LSQ_DEPTH));

  // Issue FSM, CDB wake-up, FIFO push/pop and flush, all resolved as next state.
  always_comb begin
    state_d = state_q;  head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    busy_d = busy_q;  j_d = j_q;  k_d = k_q;  op_d = op_q;  vj_d = vj_q;
    vk_d = vk_q;  imm_d = imm_q;  qj_d = qj_q;  qk_d = qk_q;  tag_d = tag_q;
    goWork_d = goWork_q;  lOrS_d = lOrS_q;  width_d = width_q;
    address_d = address_q;  valueStore_d = valueStore_q;
    issuedTag_d = issuedTag_q;  issuedOp_d = issuedOp_q;  flushed_d = flushed_q;
    lbToRob_d = 1'b0;  sbToRob_d = 1'b0;
    loadId_d = loadId_q;  storeId_d = storeId_q;  value_d = value_q;
    push = task_in && !lsq_full && !flush_in;
    pop = 1'b0;
    loadBcast = 1'b0;
    discard = flushed_q || flush_in;

    case (state_q)
      IDLE: begin
        if (!flush_in && count_q != '0 && j_q[head_q] && k_q[head_q] &&
            (!isStore(headOp) || rob_head == tag_q[head_q])) begin
          state_d      = WAIT_ACK;
          goWork_d     = 1'b1;
          lOrS_d       = isStore(headOp);
          width_d      = headWidth;
          address_d    = vj_q[head_q] + imm_q[head_q];
          valueStore_d = vk_q[head_q] & widthMask(headWidth);
          issuedTag_d  = tag_q[head_q];
          issuedOp_d   = headOp;
          flushed_d    = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (received) begin
          goWork_d  = 1'b0;
          pop       = !discard;
          flushed_d = lOrS_q ? 1'b0 : discard;
          state_d   = lOrS_q ? IDLE : WAIT_DATA;
          if (lOrS_q && !discard) begin
            sbToRob_d = 1'b1;
            storeId_d = issuedTag_q;
          end
        end else if (flush_in) begin
          if (lOrS_q) begin
            flushed_d = 1'b1;
          end else begin
            goWork_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      WAIT_DATA: begin
        if (has_result) begin
          state_d   = IDLE;
          flushed_d = 1'b0;
          if (!discard) begin
            lbToRob_d = 1'b1;
            loadId_d  = issuedTag_q;
            value_d   = extValue;
            loadBcast = 1'b1;
          end
        end else if (flush_in) begin
          flushed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < LSQ_DEPTH; i++) begin
      if (busy_q[i]) begin
        if (loadBcast && !j_q[i] && qj_q[i] == issuedTag_q) begin
          j_d[i] = 1'b1;  vj_d[i] = extValue;
        end
        if (loadBcast && !k_q[i] && qk_q[i] == issuedTag_q) begin
          k_d[i] = 1'b1;  vk_d[i] = extValue;
        end
`ifdef LSQ_ALU_SNOOP_EN
        if (alu_valid && !j_q[i] && qj_q[i] == alu_id) begin
          j_d[i] = 1'b1;  vj_d[i] = alu_value;
        end
        if (alu_valid && !k_q[i] && qk_q[i] == alu_id) begin
          k_d[i] = 1'b1;  vk_d[i] = alu_value;
        end
`endif
      end
    end

    if (pop) begin
      busy_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
    end

    if (push) begin
      busy_d[tail_q] = 1'b1;  op_d[tail_q] = op_type;  imm_d[tail_q] = imm_in;
      tag_d[tail_q] = dest_in;  qj_d[tail_q] = qj_in;  qk_d[tail_q] = qk_in;
      j_d[tail_q] = j_in;  vj_d[tail_q] = vj_in;
      k_d[tail_q] = k_in;  vk_d[tail_q] = vk_in;
      if (loadBcast && !j_in && qj_in == issuedTag_q) begin
        j_d[tail_q] = 1'b1;  vj_d[tail_q] = extValue;
      end
      if (loadBcast && !k_in && qk_in == issuedTag_q) begin
        k_d[tail_q] = 1'b1;  vk_d[tail_q] = extValue;
      end
`ifdef LSQ_ALU_SNOOP_EN
      if (alu_valid && !j_in && qj_in == alu_id) begin
        j_d[tail_q] = 1'b1;  vj_d[tail_q] = alu_value;
      end
      if (alu_valid && !k_in && qk_in == alu_id) begin
        k_d[tail_q] = 1'b1;  vk_d[tail_q] = alu_value;
      end
`endif
      tail_d = tail_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (flush_in) begin
      busy_d = '0;  head_d = '0;  tail_d = '0;  count_d = '0;
    end
  end

  // Control state and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;  head_q <= '0;  tail_q <= '0;  count_q <= '0;
      busy_q <= '0;  j_q <= '0;  k_q <= '0;
      goWork_q <= 1'b0;  lOrS_q <= 1'b0;  width_q <= '0;  address_q <= '0;
      valueStore_q <= '0;  issuedTag_q <= '0;  issuedOp_q <= '0;  flushed_q <= 1'b0;
      lbToRob_q <= 1'b0;  sbToRob_q <= 1'b0;  loadId_q <= '0;  storeId_q <= '0;
      value_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;  head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      busy_q <= busy_d;  j_q <= j_d;  k_q <= k_d;
      goWork_q <= goWork_d;  lOrS_q <= lOrS_d;  width_q <= width_d;
      address_q <= address_d;  valueStore_q <= valueStore_d;
      issuedTag_q <= issuedTag_d;  issuedOp_q <= issuedOp_d;  flushed_q <= flushed_d;
      lbToRob_q <= lbToRob_d;  sbToRob_q <= sbToRob_d;  loadId_q <= loadId_d;
      storeId_q <= storeId_d;  value_q <= value_d;
    end
  end

  // Entry payload; only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      op_d_to_q: begin
        op_q <= op_d;  vj_q <= vj_d;  vk_q <= vk_d;  imm_q <= imm_d;
        qj_q <= qj_d;  qk_q <= qk_d;  tag_q <= tag_d;
      end
    end
  end

  assign go_work     = goWork_q;
  assign l_or_s      = lOrS_q;
  assign width       = width_q;
  assign address     = address_q;
  assign value_store = valueStore_q;
  assign lb_to_rob   = lbToRob_q;
  assign load_id     = loadId_q;
  assign value       = value_q;
  assign sb_to_rob   = sbToRob_q;
  assign store_id    = storeId_q;

endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: directed, table-driven bench for load_store_queue.
// The ALU snoop sequence is built only when LSQ_ALU_SNOOP_EN is defined.
module tb_load_store_queue;
  import lsq_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, lsq_full, task_in;
  logic [5:0]  op_type;
  logic [31:0] vj_in, vk_in, imm_in;
  logic [3:0]  qj_in, qk_in, dest_in, rob_head;
  logic        j_in, k_in;
  logic        go_work, l_or_s, received, has_result;
  logic [2:0]  width;
  logic [31:0] address, value_store, value_load, value;
  logic        lb_to_rob, sb_to_rob;
  logic [3:0]  load_id, store_id;
`ifdef LSQ_ALU_SNOOP_EN
  logic        alu_valid;
  logic [3:0]  alu_id;
  logic [31:0] alu_value;
`endif

  int totalChecks = 0;
  int passedChecks = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, loadVal;
    logic [3:0]  tag;
    logic        store;
    logic [31:0] expAddr;
    logic [2:0]  expWidth;
    logic [31:0] expStore, expValue;
  } vec_t;

  vec_t vecs [8];

  load_store_queue #(.LSQ_DEPTH(16), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .lsq_full(lsq_full), .task_in(task_in), .op_type(op_type),
    .vj_in(vj_in), .vk_in(vk_in), .imm_in(imm_in), .qj_in(qj_in), .qk_in(qk_in),
    .j_in(j_in), .k_in(k_in), .dest_in(dest_in),
    .go_work(go_work), .l_or_s(l_or_s), .width(width), .address(address),
    .value_store(value_store), .received(received), .has_result(has_result),
    .value_load(value_load), .rob_head(rob_head),
`ifdef LSQ_ALU_SNOOP_EN
    .alu_valid(alu_valid), .alu_id(alu_id), .alu_value(alu_value),
`endif
    .lb_to_rob(lb_to_rob), .load_id(load_id), .value(value),
    .sb_to_rob(sb_to_rob), .store_id(store_id)
  );

  // Free-running 10-unit clock.
  always #5 clk_in = ~clk_in;

  // Hard time limit so a wedged design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [31:0] imm, input logic [3:0] qj, input logic [3:0] qk,
                               input logic j, input logic k, input logic [3:0] dest);
    op_type = op;  vj_in = vj;  vk_in = vk;  imm_in = imm;
    qj_in = qj;  qk_in = qk;  j_in = j;  k_in = k;  dest_in = dest;
    task_in = 1'b1;
    tick();
    task_in = 1'b0;
  endtask

  task automatic waitGoWork(input string name);
    for (int c = 0; c < 20; c++) begin
      if (go_work) break;
      tick();
    end
    checkOutput(name, {31'd0, go_work}, 32'd1);
  endtask

  task automatic completeLoad(input string name, input logic [31:0] raw, input logic [3:0] tag,
                              input logic [31:0] expVal);
    received = 1'b1;
    tick();
    received = 1'b0;
    checkOutput({name, " go_work drop"}, {31'd0, go_work}, 32'd0);
    has_result = 1'b1;  value_load = raw;
    tick();
    has_result = 1'b0;
    checkOutput({name, " lb_to_rob"}, {31'd0, lb_to_rob}, 32'd1);
    checkOutput({name, " load_id"}, {28'd0, load_id}, {28'd0, tag});
    checkOutput({name, " value"}, value, expVal);
    tick();
    checkOutput({name, " lb_to_rob pulse"}, {31'd0, lb_to_rob}, 32'd0);
  endtask

  task automatic completeStore(input string name, input logic [3:0] tag);
    received = 1'b1;
    tick();
    received = 1'b0;
    checkOutput({name, " sb_to_rob"}, {31'd0, sb_to_rob}, 32'd1);
    checkOutput({name, " store_id"}, {28'd0, store_id}, {28'd0, tag});
    checkOutput({name, " go_work drop"}, {31'd0, go_work}, 32'd0);
    tick();
    checkOutput({name, " sb_to_rob pulse"}, {31'd0, sb_to_rob}, 32'd0);
  endtask

  // Directed stimulus: reset, vector table, then multi-cycle corner cases.
  initial begin
    vecs[0] = '{op:OP_LW,  vj:32'h100,  vk:32'h0,        imm:32'h4,        loadVal:32'h8000_0001, tag:4'd1,
                store:1'b0, expAddr:32'h104,  expWidth:3'd4, expStore:32'h0, expValue:32'h8000_0001};
    vecs[1] = '{op:OP_LB,  vj:32'h200,  vk:32'h0,        imm:32'h0,        loadVal:32'h0000_00F0, tag:4'd2,
                store:1'b0, expAddr:32'h200,  expWidth:3'd1, expStore:32'h0, expValue:32'hFFFF_FFF0};
    vecs[2] = '{op:OP_LBU, vj:32'h200,  vk:32'h0,        imm:32'h1,        loadVal:32'h0000_00F0, tag:4'd3,
                store:1'b0, expAddr:32'h201,  expWidth:3'd1, expStore:32'h0, expValue:32'h0000_00F0};
    vecs[3] = '{op:OP_LH,  vj:32'h300,  vk:32'h0,        imm:32'h2,        loadVal:32'h0000_8001, tag:4'd4,
                store:1'b0, expAddr:32'h302,  expWidth:3'd2, expStore:32'h0, expValue:32'hFFFF_8001};
    vecs[4] = '{op:OP_LHU, vj:32'h300,  vk:32'h0,        imm:32'h2,        loadVal:32'h1234_8001, tag:4'd5,
                store:1'b0, expAddr:32'h302,  expWidth:3'd2, expStore:32'h0, expValue:32'h0000_8001};
    vecs[5] = '{op:OP_SW,  vj:32'h10,   vk:32'hDEAD_BEEF, imm:32'hFFFF_FFF0, loadVal:32'h0,        tag:4'd6,
                store:1'b1, expAddr:32'h0,    expWidth:3'd4, expStore:32'hDEAD_BEEF, expValue:32'h0};
    vecs[6] = '{op:OP_SH,  vj:32'h1000, vk:32'h1234_5678, imm:32'h6,        loadVal:32'h0,        tag:4'd7,
                store:1'b1, expAddr:32'h1006, expWidth:3'd2, expStore:32'h0000_5678, expValue:32'h0};
    vecs[7] = '{op:OP_SB,  vj:32'h2000, vk:32'hAABB_CCDD, imm:32'h0,        loadVal:32'h0,        tag:4'd8,
                store:1'b1, expAddr:32'h2000, expWidth:3'd1, expStore:32'h0000_00DD, expValue:32'h0};

    rst_in = 1'b0;  rdy_in = 1'b1;  flush_in = 1'b0;  task_in = 1'b0;
    op_type = '0;  vj_in = '0;  vk_in = '0;  imm_in = '0;  qj_in = '0;  qk_in = '0;
    j_in = 1'b0;  k_in = 1'b0;  dest_in = '0;  rob_head = '0;
    received = 1'b0;  has_result = 1'b0;  value_load = '0;
`ifdef LSQ_ALU_SNOOP_EN
    alu_valid = 1'b0;  alu_id = '0;  alu_value = '0;
`endif
    tick();
    tick();
    checkOutput("reset go_work", {31'd0, go_work}, 32'd0);
    checkOutput("reset lb_to_rob", {31'd0, lb_to_rob}, 32'd0);
    checkOutput("reset sb_to_rob", {31'd0, sb_to_rob}, 32'd0);
    checkOutput("reset lsq_full", {31'd0, lsq_full}, 32'd0);
    checkOutput("reset address", address, 32'd0);
    checkOutput("reset width", {29'd0, width}, 32'd0);
    checkOutput("reset value", value, 32'd0);
    rst_in = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      rob_head = vecs[v].tag;
      applyStimulus(vecs[v].op, vecs[v].vj, vecs[v].vk, vecs[v].imm, 4'd0, 4'd0, 1'b1, 1'b1, vecs[v].tag);
      waitGoWork($sformatf("vec%0d go_work", v));
      checkOutput($sformatf("vec%0d address", v), address, vecs[v].expAddr);
      checkOutput($sformatf("vec%0d width", v), {29'd0, width}, {29'd0, vecs[v].expWidth});
      checkOutput($sformatf("vec%0d l_or_s", v), {31'd0, l_or_s}, {31'd0, vecs[v].store});
      if (vecs[v].store) begin
        checkOutput($sformatf("vec%0d value_store", v), value_store, vecs[v].expStore);
        completeStore($sformatf("vec%0d", v), vecs[v].tag);
      end else begin
        completeLoad($sformatf("vec%0d", v), vecs[v].loadVal, vecs[v].tag, vecs[v].expValue);
      end
    end

    // Store waits for its ROB turn.
    rob_head = 4'd2;
    applyStimulus(OP_SB, 32'h40, 32'hABCD_EFFF, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
    tick();  tick();  tick();
    checkOutput("sb not head go_work", {31'd0, go_work}, 32'd0);
    rob_head = 4'd3;
    waitGoWork("sb at head go_work");
    checkOutput("sb value_store", value_store, 32'h0000_00FF);
    checkOutput("sb address", address, 32'h40);
    completeStore("sb tag3", 4'd3);

    // Fill to full, drop the extra push, then push and pop together at full-1.
    rob_head = 4'd9;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(OP_SB, i * 16, i, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'(i));
    end
    checkOutput("fill lsq_full", {31'd0, lsq_full}, 32'd1);
    applyStimulus(OP_SB, 32'h999, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
    tick();  tick();
    checkOutput("extra push dropped go_work", {31'd0, go_work}, 32'd0);
    checkOutput("extra push lsq_full", {31'd0, lsq_full}, 32'd1);
    rob_head = 4'd0;
    waitGoWork("fill head0 go_work");
    checkOutput("fill head0 address", address, 32'h0);
    completeStore("fill head0", 4'd0);
    checkOutput("after pop lsq_full", {31'd0, lsq_full}, 32'd0);
    rob_head = 4'd1;
    waitGoWork("fill head1 go_work");
    checkOutput("fill head1 address", address, 32'h10);
    received = 1'b1;
    applyStimulus(OP_SB, 32'hAAA, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'hA);
    received = 1'b0;
    checkOutput("push+pop lsq_full", {31'd0, lsq_full}, 32'd0);
    applyStimulus(OP_SB, 32'hBBB, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'hB);
    checkOutput("push+pop count held", {31'd0, lsq_full}, 32'd1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checkOutput("flush lsq_full", {31'd0, lsq_full}, 32'd0);
    rob_head = 4'd2;
    tick();  tick();  tick();
    checkOutput("flush empties queue", {31'd0, go_work}, 32'd0);

    // Flush while a load waits for data.
    applyStimulus(OP_LW, 32'h500, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5);
    waitGoWork("flushload go_work");
    received = 1'b1;
    tick();
    received = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    has_result = 1'b1;  value_load = 32'h1234;
    tick();
    has_result = 1'b0;
    checkOutput("flushload no lb_to_rob", {31'd0, lb_to_rob}, 32'd0);
    tick();  tick();
    checkOutput("flushload queue empty", {31'd0, go_work}, 32'd0);
    applyStimulus(OP_LW, 32'h600, 32'h0, 32'h10, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
    waitGoWork("postflush go_work");
    checkOutput("postflush address", address, 32'h610);
    completeLoad("postflush", 32'h55, 4'd6, 32'h55);

    // Load result wakes a queued entry and bypasses into a same-cycle dispatch.
    applyStimulus(OP_LW, 32'h700, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
    waitGoWork("bypass producer go_work");
    applyStimulus(OP_LW, 32'h0, 32'h0, 32'h100, 4'd6, 4'd0, 1'b0, 1'b1, 4'd8);
    received = 1'b1;
    tick();
    received = 1'b0;
    has_result = 1'b1;  value_load = 32'h40;
    applyStimulus(OP_LW, 32'hDEAD, 32'h0, 32'h8, 4'd6, 4'd0, 1'b0, 1'b1, 4'd7);
    has_result = 1'b0;
    checkOutput("bypass producer lb_to_rob", {31'd0, lb_to_rob}, 32'd1);
    checkOutput("bypass producer value", value, 32'h40);
    checkOutput("bypass producer load_id", {28'd0, load_id}, 32'd6);
    waitGoWork("wakeup go_work");
    checkOutput("wakeup address", address, 32'h140);
    completeLoad("wakeup", 32'h11, 4'd8, 32'h11);
    waitGoWork("bypass go_work");
    checkOutput("bypass address", address, 32'h48);
    completeLoad("bypass", 32'h22, 4'd7, 32'h22);

`ifdef LSQ_ALU_SNOOP_EN
    // ALU broadcast bypassed into the dispatching entry.
    alu_valid = 1'b1;  alu_id = 4'd5;  alu_value = 32'h20;
    applyStimulus(OP_LW, 32'hBAD, 32'h0, 32'h0, 4'd5, 4'd0, 1'b0, 1'b1, 4'd9);
    alu_valid = 1'b0;
    waitGoWork("alu bypass go_work");
    checkOutput("alu bypass address", address, 32'h20);
    completeLoad("alu bypass", 32'h33, 4'd9, 32'h33);
`endif

    // Stall holds an outstanding access; reset then abandons it.
    applyStimulus(OP_LW, 32'h800, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd10);
    waitGoWork("stall go_work");
    rdy_in = 1'b0;  received = 1'b1;
    tick();
    checkOutput("stall holds go_work", {31'd0, go_work}, 32'd1);
    received = 1'b0;  rdy_in = 1'b1;  rst_in = 1'b0;
    tick();
    checkOutput("midreset go_work", {31'd0, go_work}, 32'd0);
    checkOutput("midreset address", address, 32'd0);
    rst_in = 1'b1;
    tick();  tick();  tick();
    checkOutput("midreset queue empty", {31'd0, go_work}, 32'd0);
    checkOutput("midreset lb_to_rob", {31'd0, lb_to_rob}, 32'd0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter LSQ_DEPTH, default 16, entry count (power of two, at least 2).
REQ-002 SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-003 SHALL have ports clk_in (in, 1, clock) and rst_in (in, 1, reset); one clock; reset is synchronous and active-low.
REQ-004 SHALL have rdy_in (in, 1): when 0, all state holds.
REQ-005 SHALL have flush_in (in, 1): mispredict flush.
REQ-006 SHALL have lsq_full (out, 1): count equals LSQ_DEPTH.
REQ-007 SHALL have dispatch inputs:
- task_in (in, 1).
- op_type (in, 6): 10 LB, 11 LH, 12 LW, 13 LBU, 14 LHU, 15 SB, 16 SH, 17 SW.
- vj_in, vk_in, imm_in (in, 32 each).
- qj_in, qk_in (in, ROB_W each).
- j_in, k_in (in, 1 each): operand ready.
- dest_in (in, ROB_W): ROB tag.
REQ-008 SHALL have memctrl ports:
- go_work (out, 1).
- l_or_s (out, 1): 0 load, 1 store.
- width (out, 3): byte count.
- address, value_store (out, 32 each).
- received (in, 1).
- has_result (in, 1).
- value_load (in, 32).
REQ-009 SHALL have rob_head (in, ROB_W).
REQ-010 SHALL have ALU CDB snoop inputs alu_valid (in, 1), alu_id (in, ROB_W), alu_value (in, 32).
REQ-011 SHALL have CDB outputs:
- lb_to_rob (out, 1), load_id (out, ROB_W), value (out, 32).
- sb_to_rob (out, 1), store_id (out, ROB_W).

Function
REQ-012 SHALL be a circular FIFO with head, tail and count; pointers wrap modulo LSB_DEPTH; full and empty SHALL come from count only.
REQ-013 SHALL ignore task_in when lsq_full=1.
REQ-014 SHALL have issue FSM states IDLE, WAIT_ACK, WAIT_DATA.
REQ-015 SHALL leave IDLE only when all hold: FIFO non-empty, head j=1, head k=1.
- Load: go to WAIT_ACK.
- Store: go to WAIT_ACK only when rob_head equals the head tag.
REQ-016 SHALL issue on entering WAIT_ACK: go_work=1, address=vj+imm (mod 2^32), width 1/2/4 by op, value_store=vk masked to width.
REQ-017 SHALL, in WAIT_ACK, hold all memctrl outputs stable until received=1, then drive go_work=0 and pop head.
- Store: pulse sb_to_rob=1 for one cycle with store_id=tag; go to IDLE.
- Load: go to WAIT_DATA.
REQ-018 SHALL, in WAIT_DATA on has_result=1, pulse lb_to_rob=1 for one cycle, set load_id=issued tag, and go to IDLE.
- value: LB, LH sign-extend; LBU, LHU zero-extend; LW passes through.
REQ-019 SHALL wake up every busy entry on a load result or ALU broadcast: where q matches and the ready bit is 0, set ready=1 and capture the value.
REQ-020 SHALL apply a broadcast matching qj_in or qk_in in the same cycle as task_in to the entry being written (bypass).
REQ-021 SHALL, when a push and a pop occur in the same cycle, leave count unchanged; a push is allowed then even when count equals LSB_DEPTH-1.
REQ-022 SHALL, on flush_in=1, clear all entries, head, tail and count.
- WAIT_ACK with a store: complete the store, suppress sb_to_rob.
- WAIT_ACK with a load: drop go_work, go to IDLE.
- WAIT_DATA: discard the next has_result, raise no lb_to_rob.
- task_in in the same cycle is ignored.
REQ-023 SHALL accept at most one dispatch and one issue per cycle.

Reset
REQ-024 SHALL, on rst_in=0 at a clock edge, set head=tail=count=0, all busy=0, FSM=IDLE.
REQ-025 SHALL, on reset, set go_work, lb_to_rob and sb_to_rob to 0, and l_or_s, width, address, value_store, load_id, store_id and value to 0.
REQ-026 SHALL abandon any memory transaction in flight when reset is asserted mid-operation.

Configuration
REQ-027 SHALL compile the ALU snoop port and its wake-up logic only when macro LSQ_ALU_SNOOP_EN is defined.
- Without the macro: alu_* ports are absent and only load results wake entries.

Structure
REQ-028 SHALL take op codes, FSM state encoding and the width table from shared package lsq_pkg.
REQ-029 SHALL place extension in one sub-module, load_extend: op and raw word in, extended word out, combinational.

Verification
REQ-030 SHALL cover: LW with vj=0x100, imm=4, value_load=0x80000001 -> address 0x104, width 4, lb_to_rob with value 0x80000001.
REQ-031 SHALL cover: LB and LBU of 0x000000F0 -> 0xFFFFFFF0 and 0x000000F0.
REQ-032 SHALL cover: SB at head with tag 3 and rob_head=2 -> no go_work; rob_head=3 -> go_work=1, value_store masked 0xFF, sb_to_rob with store_id=3.
REQ-033 SHALL cover: fill to LSB_DEPTH -> lsq_full=1 and the extra push dropped; simultaneous push and pop at full-1 -> count held.
REQ-034 SHALL cover: load in WAIT_DATA plus flush_in -> following has_result yields no lb_to_rob, queue empty.
REQ-035 SHALL cover: dispatch with qj=5 in the same cycle as alu_id=5, alu_value=0x20 -> entry vj=0x20, j=1.
